lenet_load_sequencer: RTL and testbench

Control and sequencing block between the AXI4-Lite register slave and the LeNet inference core. Decodes register-write strobes into three parameter streams: weights, biases and feature map. Each stream is written into its on-chip memory at an auto-incrementing address. Once every stream is complete, the block issues a single start pulse to the core, latches the classification result on completion, and serves the status/result read registers.

---
 rtl/lenet_load_sequencer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_lenet_load_sequencer.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lenet_load_sequencer.sv
// lenet_load_sequencer: decodes register writes into weight/bias/fmap memory
// streams, starts the LeNet core once all streams are loaded, latches the
// class result and serves the status/result read registers.
module lenet_load_sequencer #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned N_WEIGHT = 3220,
  parameter int unsigned N_BIAS   = 10,
  parameter int unsigned N_FMAP   = 784,
  parameter int unsigned RESULT_W = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        reg_wr_en,
  input  logic [4:0]                  reg_wr_addr,
  input  logic [DATA_W-1:0]           reg_wr_data,
  input  logic                        reg_rd_en,
  input  logic [4:0]                  reg_rd_addr,
  output logic [DATA_W-1:0]           reg_rd_data,
  output logic                        w_we,
  output logic [$clog2(N_WEIGHT)-1:0] w_addr,
  output logic [DATA_W-1:0]           w_wdata,
  output logic                        b_we,
  output logic [$clog2(N_BIAS)-1:0]   b_addr,
  output logic [DATA_W-1:0]           b_wdata,
  output logic                        f_we,
  output logic [$clog2(N_FMAP)-1:0]   f_addr,
  output logic [DATA_W-1:0]           f_wdata,
  output logic                        core_start,
  input  logic                        core_done,
  input  logic [RESULT_W-1:0]         core_result
);

  localparam int unsigned W_AW = $clog2(N_WEIGHT);
  localparam int unsigned B_AW = $clog2(N_BIAS);
  localparam int unsigned F_AW = $clog2(N_FMAP);
  // Counters must be able to hold N_* itself (saturation value).
  localparam int unsigned W_CW = $clog2(N_WEIGHT + 1);
  localparam int unsigned B_CW = $clog2(N_BIAS + 1);
  localparam int unsigned F_CW = $clog2(N_FMAP + 1);

  localparam logic [4:0] A_CTRL   = 5'h00;
  localparam logic [4:0] A_WEIGHT = 5'h04;
  localparam logic [4:0] A_BIAS   = 5'h08;
  localparam logic [4:0] A_FMAP   = 5'h0C;
  localparam logic [4:0] A_STATUS = 5'h10;
  localparam logic [4:0] A_DONE   = 5'h14;
  localparam logic [4:0] A_RESULT = 5'h18;
  localparam logic [4:0] A_SRST   = 5'h1C;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  ctrl_q, ctrl_d;
  logic                  srst_q, srst_d;
  logic [W_CW-1:0]       w_cnt_q, w_cnt_d;
  logic [B_CW-1:0]       b_cnt_q, b_cnt_d;
  logic [F_CW-1:0]       f_cnt_q, f_cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  ord_q, ord_d;
  logic                  done_q, done_d;
  logic [RESULT_W-1:0]   result_q, result_d;
  logic                  start_q, start_d;
  logic                  w_we_q, w_we_d;
  logic [W_AW-1:0]       w_addr_q, w_addr_d;
  logic [DATA_W-1:0]     w_wdata_q, w_wdata_d;
  logic                  b_we_q, b_we_d;
  logic [B_AW-1:0]       b_addr_q, b_addr_d;
  logic [DATA_W-1:0]     b_wdata_q, b_wdata_d;
  logic                  f_we_q, f_we_d;
  logic [F_AW-1:0]       f_addr_q, f_addr_d;
  logic [DATA_W-1:0]     f_wdata_q, f_wdata_d;
  logic [DATA_W-1:0]     rd_data_q, rd_data_d;

  logic wr_ctrl, wr_srst, wr_w, wr_b, wr_f;
  logic w_full, b_full, f_full;

  assign wr_ctrl = reg_wr_en && (reg_wr_addr == A_CTRL);
  assign wr_srst = reg_wr_en && (reg_wr_addr == A_SRST);
  assign wr_w    = reg_wr_en && (reg_wr_addr == A_WEIGHT);
  assign wr_b    = reg_wr_en && (reg_wr_addr == A_BIAS);
  assign wr_f    = reg_wr_en && (reg_wr_addr == A_FMAP);

  assign w_full = (w_cnt_q == W_CW'(N_WEIGHT));
  assign b_full = (b_cnt_q == B_CW'(N_BIAS));
  assign f_full = (f_cnt_q == F_CW'(N_FMAP));

  // Next-state: read decode, soft reset, CTRL clear, FSM and stream pushes.
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    srst_d    = srst_q;
    w_cnt_d   = w_cnt_q;
    b_cnt_d   = b_cnt_q;
    f_cnt_d   = f_cnt_q;
    ovf_d     = ovf_q;
    ord_d     = ord_q;
    done_d    = done_q;
    result_d  = result_q;
    start_d   = 1'b0;
    w_we_d    = 1'b0;
    w_addr_d  = w_addr_q;
    w_wdata_d = w_wdata_q;
    b_we_d    = 1'b0;
    b_addr_d  = b_addr_q;
    b_wdata_d = b_wdata_q;
    f_we_d    = 1'b0;
    f_addr_d  = f_addr_q;
    f_wdata_d = f_wdata_q;
    rd_data_d = '0;

    // Reads see the pre-update register values.
    if (reg_rd_en) begin
      case (reg_rd_addr)
        A_CTRL:   rd_data_d = DATA_W'(ctrl_q);
        A_STATUS: rd_data_d = DATA_W'({ord_q, ovf_q, 1'b0, 2'(state_q)});
        A_DONE:   rd_data_d = DATA_W'(done_q);
        A_RESULT: rd_data_d = DATA_W'(result_q);
        A_SRST:   rd_data_d = DATA_W'(srst_q);
        default:  rd_data_d = '0;
      endcase
    end

    if (wr_srst) srst_d = reg_wr_data[0];

    if (srst_d) begin
      // Soft reset holds everything but SRST at its reset value.
      state_d   = S_IDLE;
      ctrl_d    = 1'b0;
      w_cnt_d   = '0;
      b_cnt_d   = '0;
      f_cnt_d   = '0;
      ovf_d     = 1'b0;
      ord_d     = 1'b0;
      done_d    = 1'b0;
      result_d  = '0;
      w_addr_d  = '0;
      w_wdata_d = '0;
      b_addr_d  = '0;
      b_wdata_d = '0;
      f_addr_d  = '0;
      f_wdata_d = '0;
    end else if (wr_ctrl && !reg_wr_data[0]) begin
      // Disable returns to IDLE and wins over a concurrent core_done.
      state_d  = S_IDLE;
      ctrl_d   = 1'b0;
      w_cnt_d  = '0;
      b_cnt_d  = '0;
      f_cnt_d  = '0;
      ovf_d    = 1'b0;
      ord_d    = 1'b0;
      done_d   = 1'b0;
      result_d = '0;
    end else begin
      if (wr_ctrl) ctrl_d = 1'b1;

      case (state_q)
        S_IDLE: if (wr_ctrl) state_d = S_LOAD;
        S_LOAD: begin
          if (w_full && b_full && f_full) begin
            state_d = S_RUN;
            start_d = 1'b1;
          end
        end
        S_RUN: begin
          if (core_done) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = core_result;
          end
        end
        default: state_d = state_q;
      endcase

      if (wr_w) begin
        if (state_q != S_LOAD) ord_d = 1'b1;
        else if (w_full) ovf_d = 1'b1;
        else begin
          w_we_d    = 1'b1;
          w_addr_d  = W_AW'(w_cnt_q);
          w_wdata_d = reg_wr_data;
          w_cnt_d   = w_cnt_q + W_CW'(1);
        end
      end

      if (wr_b) begin
        if (state_q != S_LOAD) ord_d = 1'b1;
        else if (b_full) ovf_d = 1'b1;
        else begin
          b_we_d    = 1'b1;
          b_addr_d  = B_AW'(b_cnt_q);
          b_wdata_d = reg_wr_data;
          b_cnt_d   = b_cnt_q + B_CW'(1);
        end
      end

      if (wr_f) begin
        if (state_q != S_LOAD) ord_d = 1'b1;
        else if (f_full) ovf_d = 1'b1;
        else begin
          f_we_d    = 1'b1;
          f_addr_d  = F_AW'(f_cnt_q);
          f_wdata_d = reg_wr_data;
          f_cnt_d   = f_cnt_q + F_CW'(1);
        end
      end
    end
  end

  // State and registered outputs; async reset clears everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ctrl_q    <= 1'b0;
      srst_q    <= 1'b0;
      w_cnt_q   <= '0;
      b_cnt_q   <= '0;
      f_cnt_q   <= '0;
      ovf_q     <= 1'b0;
      ord_q     <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      start_q   <= 1'b0;
      w_we_q    <= 1'b0;
      w_addr_q  <= '0;
      w_wdata_q <= '0;
      b_we_q    <= 1'b0;
      b_addr_q  <= '0;
      b_wdata_q <= '0;
      f_we_q    <= 1'b0;
      f_addr_q  <= '0;
      f_wdata_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      srst_q    <= srst_d;
      w_cnt_q   <= w_cnt_d;
      b_cnt_q   <= b_cnt_d;
      f_cnt_q   <= f_cnt_d;
      ovf_q     <= ovf_d;
      ord_q     <= ord_d;
      done_q    <= done_d;
      result_q  <= result_d;
      start_q   <= start_d;
      w_we_q    <= w_we_d;
      w_addr_q  <= w_addr_d;
      w_wdata_q <= w_wdata_d;
      b_we_q    <= b_we_d;
      b_addr_q  <= b_addr_d;
      b_wdata_q <= b_wdata_d;
      f_we_q    <= f_we_d;
      f_addr_q  <= f_addr_d;
      f_wdata_q <= f_wdata_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign reg_rd_data = rd_data_q;
  assign w_we        = w_we_q;
  assign w_addr      = w_addr_q;
  assign w_wdata     = w_wdata_q;
  assign b_we        = b_we_q;
  assign b_addr      = b_addr_q;
  assign b_wdata     = b_wdata_q;
  assign f_we        = f_we_q;
  assign f_addr      = f_addr_q;
  assign f_wdata     = f_wdata_q;
  assign core_start  = start_q;

endmodule

// File: tb/tb_lenet_load_sequencer.sv
// Testbench for lenet_load_sequencer with reduced stream sizes: directed
// vector table, hand-written corner sequences and a random run against a
// behavioural model of the register/stream rules.
module tb_lenet_load_sequencer;

  localparam int DATA_W = 32;
  localparam int NW     = 4;
  localparam int NB     = 2;
  localparam int NF     = 3;
  localparam int RW     = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              reg_wr_en;
  logic [4:0]        reg_wr_addr;
  logic [DATA_W-1:0] reg_wr_data;
  logic              reg_rd_en;
  logic [4:0]        reg_rd_addr;
  logic [DATA_W-1:0] reg_rd_data;
  logic              w_we, b_we, f_we;
  logic [1:0]        w_addr;
  logic [0:0]        b_addr;
  logic [1:0]        f_addr;
  logic [DATA_W-1:0] w_wdata, b_wdata, f_wdata;
  logic              core_start;
  logic              core_done;
  logic [RW-1:0]     core_result;

  lenet_load_sequencer #(
    .DATA_W(DATA_W), .N_WEIGHT(NW), .N_BIAS(NB), .N_FMAP(NF), .RESULT_W(RW)
  ) dut (
    .clock(clock), .reset(reset),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .w_we(w_we), .w_addr(w_addr), .w_wdata(w_wdata),
    .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .f_we(f_we), .f_addr(f_addr), .f_wdata(f_wdata),
    .core_start(core_start), .core_done(core_done), .core_result(core_result)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;
  int start_cnt = 0;

  // Behavioural model state.
  int          m_state;
  int          m_cnt [3];
  int          m_n   [3];
  bit          m_ovf, m_ord, m_done, m_ctrl, m_srst;
  int          m_result;
  bit          e_we   [3];
  int          e_addr [3];
  logic [31:0] e_data [3];
  bit          e_start;
  logic [31:0] e_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_state  = 0;
    m_ovf    = 0;
    m_ord    = 0;
    m_done   = 0;
    m_result = 0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
  endtask

  task automatic model_hard_reset();
    model_clear();
    m_ctrl = 0;
    m_srst = 0;
  endtask

  // One cycle of the register/stream rules; sets expected next outputs.
  task automatic model_step(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                            input bit re, input logic [4:0] ra, input bit cd,
                            input logic [3:0] cr);
    int pre;
    int k;
    e_rd = 32'h0;
    if (re) begin
      case (ra)
        5'h00:   e_rd = {31'b0, m_ctrl};
        5'h10:   e_rd = {27'b0, m_ord, m_ovf, 3'(m_state)};
        5'h14:   e_rd = {31'b0, m_done};
        5'h18:   e_rd = 32'(m_result);
        5'h1C:   e_rd = {31'b0, m_srst};
        default: e_rd = 32'h0;
      endcase
    end
    for (int i = 0; i < 3; i++) e_we[i] = 0;
    e_start = 0;
    if (we && wa == 5'h1C) m_srst = wd[0];
    if (m_srst) begin
      model_clear();
      m_ctrl = 0;
      return;
    end
    if (we && wa == 5'h00 && !wd[0]) begin
      model_clear();
      m_ctrl = 0;
      return;
    end
    pre = m_state;
    if (we && wa == 5'h00) begin
      m_ctrl = 1;
      if (pre == 0) m_state = 1;
    end
    if (pre == 1 && m_cnt[0] == m_n[0] && m_cnt[1] == m_n[1] && m_cnt[2] == m_n[2]) begin
      m_state = 2;
      e_start = 1;
    end
    if (pre == 2 && cd) begin
      m_state  = 3;
      m_done   = 1;
      m_result = int'(cr);
    end
    if (we && (wa == 5'h04 || wa == 5'h08 || wa == 5'h0C)) begin
      k = int'(wa) / 4 - 1;
      if (pre != 1) m_ord = 1;
      else if (m_cnt[k] == m_n[k]) m_ovf = 1;
      else begin
        e_we[k]   = 1;
        e_addr[k] = m_cnt[k];
        e_data[k] = wd;
        m_cnt[k]  = m_cnt[k] + 1;
      end
    end
  endtask

  task automatic compare_model();
    check("w_we", 32'(w_we), 32'(e_we[0]));
    if (e_we[0]) begin
      check("w_addr", 32'(w_addr), 32'(e_addr[0]));
      check("w_wdata", w_wdata, e_data[0]);
    end
    check("b_we", 32'(b_we), 32'(e_we[1]));
    if (e_we[1]) begin
      check("b_addr", 32'(b_addr), 32'(e_addr[1]));
      check("b_wdata", b_wdata, e_data[1]);
    end
    check("f_we", 32'(f_we), 32'(e_we[2]));
    if (e_we[2]) begin
      check("f_addr", 32'(f_addr), 32'(e_addr[2]));
      check("f_wdata", f_wdata, e_data[2]);
    end
    check("core_start", 32'(core_start), 32'(e_start));
    check("reg_rd_data", reg_rd_data, e_rd);
  endtask

  // Drive one cycle, step the model, sample #1 after the edge and compare.
  task automatic cyc(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                     input bit re, input logic [4:0] ra, input bit cd,
                     input logic [3:0] cr);
    reg_wr_en   = we;
    reg_wr_addr = wa;
    reg_wr_data = wd;
    reg_rd_en   = re;
    reg_rd_addr = ra;
    core_done   = cd;
    core_result = cr;
    model_step(we, wa, wd, re, ra, cd, cr);
    @(posedge clock);
    #1;
    if (core_start) start_cnt++;
    compare_model();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cyc(1'b1, a, d, 1'b0, 5'h0, 1'b0, 4'h0);
  endtask

  task automatic idle();
    cyc(1'b0, 5'h0, 32'h0, 1'b0, 5'h0, 1'b0, 4'h0);
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    cyc(1'b0, 5'h0, 32'h0, 1'b1, a, 1'b0, 4'h0);
    check(name, reg_rd_data, exp);
  endtask

  task automatic load_image();
    wr(5'h00, 32'h1);
    for (int i = 0; i < NW; i++) wr(5'h04, $urandom);
    for (int i = 0; i < NB; i++) wr(5'h08, $urandom);
    for (int i = 0; i < NF; i++) wr(5'h0C, $urandom);
    idle();
    idle();
  endtask

  typedef struct {
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    bit          re;
    logic [4:0]  ra;
    bit          cd;
    logic [3:0]  cr;
    logic [31:0] x_rd;
    bit          x_start;
    int          x_port;   // 0 none, 1 weight, 2 bias, 3 fmap
    int          x_addr;
    logic [31:0] x_data;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit we, logic [4:0] wa, logic [31:0] wd, bit re,
                              logic [4:0] ra, bit cd, logic [3:0] cr,
                              logic [31:0] x_rd, bit x_start, int x_port,
                              int x_addr, logic [31:0] x_data);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.cd = cd; v.cr = cr;
    v.x_rd = x_rd; v.x_start = x_start; v.x_port = x_port;
    v.x_addr = x_addr; v.x_data = x_data;
    return v;
  endfunction

  initial begin
    bit          we, re, cd;
    logic [4:0]  wa, ra;
    logic [31:0] wd;
    int          r;

    m_n[0] = NW; m_n[1] = NB; m_n[2] = NF;
    reset = 1'b1;
    reg_wr_en = 1'b0; reg_wr_addr = 5'h0; reg_wr_data = 32'h0;
    reg_rd_en = 1'b0; reg_rd_addr = 5'h0;
    core_done = 1'b0; core_result = 4'h0;
    model_hard_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset_rd_data", reg_rd_data, 32'h0);
    check("reset_w_we", 32'(w_we), 32'h0);
    check("reset_core_start", 32'(core_start), 32'h0);
    check("reset_w_addr", 32'(w_addr), 32'h0);
    reset = 1'b0;

    // Directed table: full load, start, done/result, order error, unmapped.
    tbl.push_back(mk(0, 5'h00, 32'h00, 1, 5'h10, 0, 4'h0, 32'h00, 0, 0, 0, 32'h00));
    tbl.push_back(mk(1, 5'h00, 32'h01, 0, 5'h00, 0, 4'h0, 32'h00, 0, 0, 0, 32'h00));
    tbl.push_back(mk(1, 5'h04, 32'h11, 0, 5'h00, 0, 4'h0, 32'h00, 0, 1, 0, 32'h11));
    tbl.push_back(mk(1, 5'h04, 32'h12, 0, 5'h00, 0, 4'h0, 32'h00, 0, 1, 1, 32'h12));
    tbl.push_back(mk(1, 5'h04, 32'h13, 0, 5'h00, 0, 4'h0, 32'h00, 0, 1, 2, 32'h13));
    tbl.push_back(mk(1, 5'h04, 32'h14, 0, 5'h00, 0, 4'h0, 32'h00, 0, 1, 3, 32'h14));
    tbl.push_back(mk(1, 5'h08, 32'h21, 0, 5'h00, 0, 4'h0, 32'h00, 0, 2, 0, 32'h21));
    tbl.push_back(mk(1, 5'h08, 32'h22, 0, 5'h00, 0, 4'h0, 32'h00, 0, 2, 1, 32'h22));
    tbl.push_back(mk(1, 5'h0C, 32'h31, 0, 5'h00, 0, 4'h0, 32'h00, 0, 3, 0, 32'h31));
    tbl.push_back(mk(1, 5'h0C, 32'h32, 0, 5'h00, 0, 4'h0, 32'h00, 0, 3, 1, 32'h32));
    tbl.push_back(mk(1, 5'h0C, 32'h33, 0, 5'h00, 0, 4'h0, 32'h00, 0, 3, 2, 32'h33));
    tbl.push_back(mk(0, 5'h00, 32'h00, 1, 5'h10, 0, 4'h0, 32'h01, 1, 0, 0, 32'h00));
    tbl.push_back(mk(0, 5'h00, 32'h00, 1, 5'h10, 0, 4'h0, 32'h02, 0, 0, 0, 32'h00));
    tbl.push_back(mk(0, 5'h00, 32'h00, 1, 5'h14, 1, 4'h7, 32'h00, 0, 0, 0, 32'h00));
    tbl.push_back(mk(0, 5'h00, 32'h00, 1, 5'h14, 0, 4'h0, 32'h01, 0, 0, 0, 32'h00));
    tbl.push_back(mk(0, 5'h00, 32'h00, 1, 5'h18, 0, 4'h0, 32'h07, 0, 0, 0, 32'h00));
    tbl.push_back(mk(0, 5'h00, 32'h00, 1, 5'h10, 0, 4'h0, 32'h03, 0, 0, 0, 32'h00));
    tbl.push_back(mk(0, 5'h00, 32'h00, 1, 5'h00, 0, 4'h0, 32'h01, 0, 0, 0, 32'h00));
    tbl.push_back(mk(1, 5'h00, 32'h00, 0, 5'h00, 0, 4'h0, 32'h00, 0, 0, 0, 32'h00));
    tbl.push_back(mk(0, 5'h00, 32'h00, 1, 5'h10, 0, 4'h0, 32'h00, 0, 0, 0, 32'h00));
    tbl.push_back(mk(0, 5'h00, 32'h00, 1, 5'h18, 0, 4'h0, 32'h00, 0, 0, 0, 32'h00));
    tbl.push_back(mk(1, 5'h04, 32'h55, 0, 5'h00, 0, 4'h0, 32'h00, 0, 0, 0, 32'h00));
    tbl.push_back(mk(0, 5'h00, 32'h00, 1, 5'h10, 0, 4'h0, 32'h10, 0, 0, 0, 32'h00));
    tbl.push_back(mk(1, 5'h00, 32'h00, 0, 5'h00, 0, 4'h0, 32'h00, 0, 0, 0, 32'h00));
    tbl.push_back(mk(0, 5'h00, 32'h00, 1, 5'h10, 0, 4'h0, 32'h00, 0, 0, 0, 32'h00));
    tbl.push_back(mk(1, 5'h02, 32'hFF, 1, 5'h04, 0, 4'h0, 32'h00, 0, 0, 0, 32'h00));
    tbl.push_back(mk(0, 5'h00, 32'h00, 1, 5'h1C, 0, 4'h0, 32'h00, 0, 0, 0, 32'h00));

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra, tbl[i].cd, tbl[i].cr);
      check($sformatf("tbl%0d_rd", i), reg_rd_data, tbl[i].x_rd);
      check($sformatf("tbl%0d_start", i), 32'(core_start), 32'(tbl[i].x_start));
      check($sformatf("tbl%0d_w_we", i), 32'(w_we), 32'(tbl[i].x_port == 1));
      check($sformatf("tbl%0d_b_we", i), 32'(b_we), 32'(tbl[i].x_port == 2));
      check($sformatf("tbl%0d_f_we", i), 32'(f_we), 32'(tbl[i].x_port == 3));
      case (tbl[i].x_port)
        1: begin
          check($sformatf("tbl%0d_addr", i), 32'(w_addr), 32'(tbl[i].x_addr));
          check($sformatf("tbl%0d_data", i), w_wdata, tbl[i].x_data);
        end
        2: begin
          check($sformatf("tbl%0d_addr", i), 32'(b_addr), 32'(tbl[i].x_addr));
          check($sformatf("tbl%0d_data", i), b_wdata, tbl[i].x_data);
        end
        3: begin
          check($sformatf("tbl%0d_addr", i), 32'(f_addr), 32'(tbl[i].x_addr));
          check($sformatf("tbl%0d_data", i), f_wdata, tbl[i].x_data);
        end
        default: ;
      endcase
    end

    // Weight overflow: fifth push dropped, load still completes and starts.
    start_cnt = 0;
    wr(5'h00, 32'h1);
    for (int i = 0; i < NW; i++) wr(5'h04, 32'h100 + 32'(i));
    wr(5'h04, 32'h1FF);
    check("ovf_no_w_we", 32'(w_we), 32'h0);
    rd_chk("ovf_status_load", 5'h10, 32'h09);
    for (int i = 0; i < NB; i++) wr(5'h08, 32'h200 + 32'(i));
    for (int i = 0; i < NF; i++) wr(5'h0C, 32'h300 + 32'(i));
    idle(); idle(); idle();
    check("ovf_start_once", 32'(start_cnt), 32'h1);
    rd_chk("ovf_status_run", 5'h10, 32'h0A);
    wr(5'h00, 32'h0);

    // Soft reset mid-load: next load restarts at weight address 0.
    wr(5'h00, 32'h1);
    wr(5'h04, 32'hA0);
    wr(5'h04, 32'hA1);
    wr(5'h1C, 32'h1);
    idle();
    rd_chk("srst_reads_1", 5'h1C, 32'h1);
    rd_chk("srst_status", 5'h10, 32'h0);
    wr(5'h00, 32'h1);
    rd_chk("srst_ctrl_held", 5'h00, 32'h0);
    wr(5'h1C, 32'h0);
    wr(5'h00, 32'h1);
    wr(5'h04, 32'hAB);
    check("srst_w_we", 32'(w_we), 32'h1);
    check("srst_w_addr0", 32'(w_addr), 32'h0);
    wr(5'h00, 32'h0);

    // core_done and CTRL=0 in the same cycle: the clear wins.
    load_image();
    cyc(1'b1, 5'h00, 32'h0, 1'b0, 5'h0, 1'b1, 4'h5);
    rd_chk("clr_status", 5'h10, 32'h0);
    rd_chk("clr_done", 5'h14, 32'h0);
    rd_chk("clr_result", 5'h18, 32'h0);

    // Ten back-to-back images, one start each.
    for (int img = 0; img < 10; img++) begin
      start_cnt = 0;
      load_image();
      cyc(1'b0, 5'h0, 32'h0, 1'b0, 5'h0, 1'b1, 4'(img));
      rd_chk($sformatf("img%0d_result", img), 5'h18, 32'(img));
      rd_chk($sformatf("img%0d_done", img), 5'h14, 32'h1);
      idle();
      check($sformatf("img%0d_starts", img), 32'(start_cnt), 32'h1);
      wr(5'h00, 32'h0);
    end

    // Async reset mid-load drops an in-flight write enable immediately.
    wr(5'h00, 32'h1);
    wr(5'h04, 32'hC0);
    #2;
    reset = 1'b1;
    #1;
    check("async_w_we_drop", 32'(w_we), 32'h0);
    check("async_w_wdata", w_wdata, 32'h0);
    model_hard_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    rd_chk("async_status", 5'h10, 32'h0);
    rd_chk("async_ctrl", 5'h00, 32'h0);
    wr(5'h00, 32'h1);
    wr(5'h04, 32'hC1);
    check("async_w_addr0", 32'(w_addr), 32'h0);
    wr(5'h00, 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      r  = $urandom_range(0, 99);
      we = 1'b1;
      wd = $urandom;
      wa = 5'h0;
      if (r < 4) begin
        wa = 5'h00;
        wd = ($urandom_range(0, 9) < 7) ? 32'h1 : 32'h0;
      end else if (r < 5) begin
        wa = 5'h1C;
        wd = 32'($urandom_range(0, 1));
      end else if (r < 50) begin
        case ($urandom_range(0, 2))
          0:       wa = 5'h04;
          1:       wa = 5'h08;
          default: wa = 5'h0C;
        endcase
      end else if (r < 55) begin
        wa = 5'($urandom_range(0, 31));
        if (wa == 5'h1C || wa == 5'h00) wa = 5'h03;
      end else begin
        we = 1'b0;
      end
      re = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       ra = 5'h00;
        1:       ra = 5'h10;
        2:       ra = 5'h14;
        3:       ra = 5'h18;
        4:       ra = 5'h1C;
        default: ra = 5'($urandom_range(0, 31));
      endcase
      cd = (m_state == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      cyc(we, wa, wd, re, ra, cd, 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
